// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   sticky overflow/underflow flags, synchronous flush, an optional
//   first-word-fall-through (FWFT) read side and, in standard mode, an optional
//   extra output register stage. Storage is a simple dual-port RAM with no reset.
//
//   Parameters
//     DATA_WIDTH : word width in bits (1..256)
//     ADDR_WIDTH : depth = 2**ADDR_WIDTH words (4..12)
//     FWFT       : 0 = rd_data follows rd_en, 1 = head word shown before rd_en
//     OUT_REG    : standard mode only, 1 adds one rd_data register stage
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset (top priority)
//     flush             : synchronous clear of contents, overrides wr_en/rd_en
//     wr_en, wr_data    : write request and word
//     rd_en, rd_data    : read request (pop in FWFT mode) and read word
//     full, empty       : level == depth / no word available to read
//     almost_full       : level >= af_thresh (live threshold input)
//     almost_empty      : level <= ae_thresh (live threshold input)
//     water_level       : words written and not yet popped
//     overflow          : sticky, a write was rejected
//     underflow         : sticky, a read was rejected
//     err_clr           : clears both sticky flags (a same-cycle new error wins)
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter bit FWFT       = 1'b0,
   parameter bit OUT_REG    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic [ADDR_WIDTH:0]   af_thresh,
   input  logic [ADDR_WIDTH:0]   ae_thresh,
   output logic [ADDR_WIDTH:0]   water_level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   // Handshake: a write is taken on a rising edge where wr_en=1 and full=0; a
   // read is taken where rd_en=1 and a word is available (level!=0 in standard
   // mode, empty=0 in FWFT mode). Requests that are not taken are dropped, never
   // held, and raise the matching sticky error flag. flush and rst take neither.

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level;
   logic [DATA_WIDTH-1:0] ram_word;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_rd;   // a word leaves the RAM this cycle
   logic                  ovf_set;
   logic                  unf_set;

   // ---------------------------------------------------------------------------
   // Status flags: combinational from the registered level and live thresholds
   // ---------------------------------------------------------------------------
   assign full         = (level == DEPTH);
   assign almost_full  = (level >= af_thresh);
   assign almost_empty = (level <= ae_thresh);
   assign water_level  = level;

   assign wr_acc  = wr_en && !full && !flush;
   assign ovf_set = wr_en && full && !flush;
   assign unf_set = rd_en && !rd_acc && !flush;

   // ---------------------------------------------------------------------------
   // Storage: simple dual-port RAM, write port plus registered read address
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign ram_word = mem[rd_ptr];

   // ---------------------------------------------------------------------------
   // Pointers and level. Full/empty come from level, so pointers may simply wrap.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky error flags: set has priority over err_clr
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set | (overflow  & ~err_clr);
         underflow <= unf_set | (underflow & ~err_clr);
      end
   end

   // ---------------------------------------------------------------------------
   // Read side
   // ---------------------------------------------------------------------------
   if (FWFT == 1'b0) begin : g_std
      assign rd_acc = rd_en && (level != '0) && !flush;
      assign ram_rd = rd_acc;
      assign empty  = (level == '0);

      if (OUT_REG) begin : g_oreg
         logic [DATA_WIDTH-1:0] stage_q;
         logic                  stage_v;

         // rd_data holds on flush, so a read in flight is abandoned there.
         always_ff @(posedge clk) begin
            if (rst) begin
               stage_q <= '0;
               stage_v <= 1'b0;
               rd_data <= '0;
            end else begin
               stage_v <= rd_acc;
               if (rd_acc) begin
                  stage_q <= ram_word;
               end
               if (stage_v && !flush) begin
                  rd_data <= stage_q;
               end
            end
         end
      end else begin : g_noreg
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data <= '0;
            end else if (rd_acc) begin
               rd_data <= ram_word;
            end
         end
      end
   end else begin : g_fwft
      // Two slots sit after the RAM: a prefetch slot (mid) and the presented head
      // (rd_data). A word reaching an empty FIFO goes RAM -> mid -> head, which
      // gives the two-edge fall-through. On a pop the head refills from mid, or
      // straight from the RAM when mid is empty, so pops run at one per clock.
      logic                  head_v;
      logic                  mid_v;
      logic [DATA_WIDTH-1:0] mid_q;
      logic                  head_v_n;
      logic                  mid_v_n;
      logic                  load_head_mid;
      logic                  load_head_ram;
      logic                  load_mid;
      logic [ADDR_WIDTH:0]   unfetched;
      logic                  ram_avail;

      // Words still in the RAM = level minus the words parked in the two slots.
      assign unfetched = level - LW'(head_v) - LW'(mid_v);
      assign ram_avail = (unfetched != '0);
      assign rd_acc    = rd_en && head_v && !flush;
      assign ram_rd    = load_mid || load_head_ram;
      assign empty     = !head_v;

      always_comb begin
         head_v_n      = head_v;
         mid_v_n       = mid_v;
         load_head_mid = 1'b0;
         load_head_ram = 1'b0;
         load_mid      = 1'b0;
         if (rd_acc || !head_v) begin
            // Head slot is free after this edge.
            if (mid_v) begin
               load_head_mid = 1'b1;
               head_v_n      = 1'b1;
               load_mid      = ram_avail;
               mid_v_n       = ram_avail;
            end else if (ram_avail && rd_acc) begin
               load_head_ram = 1'b1;
               head_v_n      = 1'b1;
            end else if (ram_avail) begin
               load_mid = 1'b1;
               mid_v_n  = 1'b1;
               head_v_n = 1'b0;
            end else begin
               head_v_n = 1'b0;
            end
         end else if (!mid_v && ram_avail) begin
            load_mid = 1'b1;
            mid_v_n  = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            head_v  <= 1'b0;
            mid_v   <= 1'b0;
            mid_q   <= '0;
            rd_data <= '0;
         end else if (flush) begin
            head_v <= 1'b0;
            mid_v  <= 1'b0;
         end else begin
            head_v <= head_v_n;
            mid_v  <= mid_v_n;
            if (load_mid) begin
               mid_q <= ram_word;
            end
            if (load_head_mid) begin
               rd_data <= mid_q;
            end else if (load_head_ram) begin
               rd_data <= ram_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//   Drives three sync_fifo_prog instances (standard, FWFT, standard + OUT_REG)
//   with the same stimulus. The instance under test in each phase is selected
//   by cur and compared every cycle against a queue-based reference model that
//   follows the FIFO's behavioural rules (levels, latencies, fall-through timing
//   from write/pop timestamps, sticky flags).
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;

   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int LW    = AW + 1;
   localparam int DEPTH = 1 << AW;

   // ---------------------------------------------------------------- clock/reset
   logic clk_tb = 1'b0;
   logic tb_rst;
   always #5 clk_tb = ~clk_tb;

   // ---------------------------------------------------------------- stimulus
   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic          err_clr;
   logic [DW-1:0] wr_data;
   logic [LW-1:0] af_thresh;
   logic [LW-1:0] ae_thresh;

   // ---------------------------------------------------------------- DUT outputs
   logic [DW-1:0] rd_data      [3];
   logic          full         [3];
   logic          empty        [3];
   logic          almost_full  [3];
   logic          almost_empty [3];
   logic          overflow     [3];
   logic          underflow    [3];
   logic [LW-1:0] water_level  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sync_fifo_prog #(
         .DATA_WIDTH(DW),
         .ADDR_WIDTH(AW),
         .FWFT      (g == 1),
         .OUT_REG   (g == 2)
      ) u_dut (
         .clk         (clk_tb),
         .rst         (tb_rst),
         .flush       (flush),
         .wr_en       (wr_en),
         .wr_data     (wr_data),
         .rd_en       (rd_en),
         .rd_data     (rd_data[g]),
         .full        (full[g]),
         .empty       (empty[g]),
         .almost_full (almost_full[g]),
         .almost_empty(almost_empty[g]),
         .af_thresh   (af_thresh),
         .ae_thresh   (ae_thresh),
         .water_level (water_level[g]),
         .overflow    (overflow[g]),
         .underflow   (underflow[g]),
         .err_clr     (err_clr)
      );
   end

   // ---------------------------------------------------------------- model
   int            cur;          // 0 = standard, 1 = FWFT, 2 = standard + OUT_REG
   string         phase;
   logic [DW-1:0] exp_q [$];    // words written and not yet popped
   int            wt_q  [$];    // edge number at which each word was written
   int            cyc;
   int            last_pop;
   logic [DW-1:0] exp_rd;
   logic [DW-1:0] pend_d;
   logic [DW-1:0] shown;
   bit            pend_v;
   bit            exp_ovf;
   bit            exp_unf;
   bit            vis;
   int            n_assert;
   int            n_fail;

   // Apply the FIFO rules for one rising edge using the inputs driven before it.
   task automatic model_step();
      bit            fw;
      bit            orr;
      bit            wr_ok;
      bit            rd_ok;
      bit            ovf_new;
      bit            unf_new;
      logic [DW-1:0] w;
      int            lvl;
      int            rdy;
      fw  = (cur == 1);
      orr = (cur == 2);
      w   = '0;
      cyc++;
      if (tb_rst) begin
         exp_q.delete();
         wt_q.delete();
         exp_rd   = '0;
         pend_v   = 1'b0;
         pend_d   = '0;
         shown    = '0;
         exp_ovf  = 1'b0;
         exp_unf  = 1'b0;
         last_pop = -100;
      end else begin
         lvl = exp_q.size();
         if (flush) begin
            exp_q.delete();
            wt_q.delete();
            pend_v   = 1'b0;
            last_pop = -100;
            ovf_new  = 1'b0;
            unf_new  = 1'b0;
         end else begin
            wr_ok   = wr_en && (lvl != DEPTH);
            rd_ok   = rd_en && (fw ? vis : (lvl != 0));
            ovf_new = wr_en && !wr_ok;
            unf_new = rd_en && !rd_ok;
            if (rd_ok) begin
               w = exp_q.pop_front();
               void'(wt_q.pop_front());
               last_pop = cyc;
            end
            if (orr) begin
               if (pend_v) exp_rd = pend_d;
               pend_v = rd_ok;
               if (rd_ok) pend_d = w;
            end else if (!fw && rd_ok) begin
               exp_rd = w;
            end
            if (wr_ok) begin
               exp_q.push_back(wr_data);
               wt_q.push_back(cyc);
            end
         end
         exp_ovf = ovf_new | (exp_ovf & !err_clr);
         exp_unf = unf_new | (exp_unf & !err_clr);
      end
      // FWFT presentation: a word written into an empty FIFO shows two edges
      // later; a word already stored when the previous head is popped shows at
      // that pop edge.
      vis = 1'b0;
      if (exp_q.size() != 0) begin
         rdy = (wt_q[0] < last_pop) ? last_pop : wt_q[0] + 2;
         vis = (rdy <= cyc);
      end
      if (vis) shown = exp_q[0];
   endtask

   // ---------------------------------------------------------------- scoreboard
   task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s %s: observed 0x%0h expected 0x%0h", phase, name, obs, exp);
      end
   endtask

   task automatic check_all();
      int lvl;
      bit fw;
      lvl = exp_q.size();
      fw  = (cur == 1);
      cmp("water_level",  32'(water_level[cur]),  32'(lvl));
      cmp("full",         32'(full[cur]),         32'(lvl == DEPTH));
      cmp("almost_full",  32'(almost_full[cur]),  32'(lvl >= int'(af_thresh)));
      cmp("almost_empty", 32'(almost_empty[cur]), 32'(lvl <= int'(ae_thresh)));
      cmp("empty",        32'(empty[cur]),        32'(fw ? !vis : (lvl == 0)));
      cmp("rd_data",      32'(rd_data[cur]),      32'(fw ? shown : exp_rd));
      cmp("overflow",     32'(overflow[cur]),     32'(exp_ovf));
      cmp("underflow",    32'(underflow[cur]),    32'(exp_unf));
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk_tb);
      model_step();
      #1;
      check_all();
   endtask

   task automatic set_idle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      tb_rst = 1'b1;
      tick();
      tick();
      tb_rst = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic random_cycles(input int n, input int wr_pct, input int rd_pct, input bit use_flush);
      for (int i = 0; i < n; i++) begin
         wr_en   = ($urandom_range(0, 99) < wr_pct);
         rd_en   = ($urandom_range(0, 99) < rd_pct);
         wr_data = DW'($urandom);
         err_clr = ($urandom_range(0, 99) < 5);
         flush   = use_flush && ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 10) begin
            af_thresh = LW'($urandom_range(0, DEPTH));
            ae_thresh = LW'($urandom_range(0, 16));
         end
         tick();
      end
      set_idle();
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      n_assert  = 0;
      n_fail    = 0;
      cyc       = 0;
      last_pop  = -100;
      vis       = 1'b0;
      cur       = 0;
      tb_rst    = 1'b1;
      wr_data   = '0;
      af_thresh = LW'(1011);
      ae_thresh = LW'(4);
      set_idle();

      // ---------------- standard mode, no output register
      phase = "std_reset";
      do_reset();
      cmp("rst_empty", 32'(empty[0]), 32'd1);
      cmp("rst_rd_data", 32'(rd_data[0]), 32'd0);

      phase = "std_fill";
      for (int i = 1; i <= DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_data = DW'(i);
         tick();
      end
      wr_en = 1'b0;
      cmp("full_after_fill", 32'(full[0]), 32'd1);
      cmp("level_after_fill", 32'(water_level[0]), 32'(DEPTH));
      cmp("af_1011", 32'(almost_full[0]), 32'd1);

      phase = "std_full_wr_rd";
      wr_en   = 1'b1;
      wr_data = 16'hDEAD;
      rd_en   = 1'b1;
      tick();
      set_idle();
      cmp("ovf_set", 32'(overflow[0]), 32'd1);
      cmp("level_1023", 32'(water_level[0]), 32'd1023);
      cmp("first_read", 32'(rd_data[0]), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      cmp("ovf_clr", 32'(overflow[0]), 32'd0);

      phase = "std_drain";
      rd_en = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) tick();
      rd_en = 1'b0;
      cmp("drain_empty", 32'(empty[0]), 32'd1);
      cmp("drain_last", 32'(rd_data[0]), 32'(DEPTH));
      cmp("drain_no_unf", 32'(underflow[0]), 32'd0);

      phase = "std_underflow";
      rd_en = 1'b1;
      tick();
      cmp("unf_set", 32'(underflow[0]), 32'd1);
      err_clr = 1'b1;
      tick();
      cmp("unf_set_wins", 32'(underflow[0]), 32'd1);
      rd_en = 1'b0;
      tick();
      err_clr = 1'b0;
      cmp("unf_clr", 32'(underflow[0]), 32'd0);

      phase = "std_random";
      random_cycles(400, 60, 50, 1'b0);

      phase = "std_flush";
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 500; i++) push(DW'($urandom));
      cmp("level_500", 32'(water_level[0]), 32'd500);
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'h1234;
      tick();
      set_idle();
      cmp("flush_level", 32'(water_level[0]), 32'd0);
      cmp("flush_empty", 32'(empty[0]), 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      cmp("flush_unf", 32'(underflow[0]), 32'd1);

      // ---------------- FWFT mode
      cur   = 1;
      phase = "fwft_single";
      af_thresh = LW'(1011);
      ae_thresh = LW'(4);
      do_reset();
      push(16'h00A5);
      cmp("fwft_lvl_n", 32'(water_level[1]), 32'd1);
      cmp("fwft_empty_n", 32'(empty[1]), 32'd1);
      tick();
      cmp("fwft_empty_n1", 32'(empty[1]), 32'd1);
      tick();
      cmp("fwft_data_n2", 32'(rd_data[1]), 32'h00A5);
      cmp("fwft_empty_n2", 32'(empty[1]), 32'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      cmp("fwft_pop_empty", 32'(empty[1]), 32'd1);
      cmp("fwft_pop_level", 32'(water_level[1]), 32'd0);

      phase = "fwft_level4";
      for (int i = 0; i < 4; i++) push(DW'(16'h0200 + i));
      tick();
      tick();
      cmp("ae4", 32'(almost_empty[1]), 32'd1);
      ae_thresh = LW'(3);
      #1;
      cmp("ae3_same_cycle", 32'(almost_empty[1]), 32'd0);
      check_all();
      wr_en = 1'b1;
      rd_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wr_data = DW'($urandom);
         tick();
      end
      set_idle();
      cmp("stream_level", 32'(water_level[1]), 32'd4);

      phase = "fwft_random";
      random_cycles(500, 55, 55, 1'b1);
      random_cycles(200, 90, 20, 1'b0);
      random_cycles(200, 20, 90, 1'b0);

      // ---------------- standard mode with output register
      cur   = 2;
      phase = "oreg_latency";
      af_thresh = LW'(1011);
      ae_thresh = LW'(4);
      do_reset();
      for (int i = 0; i < 20; i++) push(DW'(16'h0100 + i));
      tick();
      rd_en = 1'b1;
      tick();
      cmp("oreg_lat1", 32'(rd_data[2]), 32'd0);
      tick();
      cmp("oreg_lat2", 32'(rd_data[2]), 32'h0100);
      tick();
      cmp("oreg_lat3", 32'(rd_data[2]), 32'h0101);

      phase = "oreg_rst_mid_burst";
      wr_en   = 1'b1;
      wr_data = 16'h7777;
      tick();
      tb_rst = 1'b1;
      tick();
      tb_rst = 1'b0;
      set_idle();
      cmp("rst_rd_data", 32'(rd_data[2]), 32'd0);
      cmp("rst_level", 32'(water_level[2]), 32'd0);
      cmp("rst_empty", 32'(empty[2]), 32'd1);
      tick();
      cmp("rst_pipe_flushed", 32'(rd_data[2]), 32'd0);

      phase = "oreg_after_rst";
      for (int i = 0; i < 8; i++) push(DW'(16'h0A00 + i));
      rd_en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      rd_en = 1'b0;
      cmp("after_rst_last", 32'(rd_data[2]), 32'h0A07);
      random_cycles(300, 55, 50, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Parametrised single-clock FIFO, the next generation of the team's 1024x16 FIFO core.
- Adds a first-word-fall-through (FWFT) mode and runtime-programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Used as the sample buffer between the audio capture path and the FFT/FIR processing stages.

Parameters:
- DATA_WIDTH, 16: word width in bits, 1..256.
- ADDR_WIDTH, 10: depth is 2**ADDR_WIDTH words, 4..12.
- FWFT, 0: 0 = standard read (data follows rd_en); 1 = head word presented before rd_en.
- OUT_REG, 0: standard mode only; 1 adds one output register stage. Ignored when FWFT=1.

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: reset, synchronous, active-high.
- flush, in, 1: synchronous clear of FIFO contents.
- wr_en, in, 1: write request.
- wr_data, in, DATA_WIDTH: write word.
- rd_en, in, 1: read request (standard mode) or pop (FWFT mode).
- rd_data, out, DATA_WIDTH: read word.
- full, out, 1: level == 2**ADDR_WIDTH.
- empty, out, 1: no word available to read.
- almost_full, out, 1: level >= af_thresh.
- almost_empty, out, 1: level <= ae_thresh.
- af_thresh, in, ADDR_WIDTH+1: almost-full threshold.
- ae_thresh, in, ADDR_WIDTH+1: almost-empty threshold.
- water_level, out, ADDR_WIDTH+1: number of words written and not yet popped.
- overflow, out, 1: sticky; a write was rejected.
- underflow, out, 1: sticky; a read was rejected.
- err_clr, in, 1: clears overflow and underflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Pointers, water_level and rd_data are 0; the FWFT head-valid flag is 0.
  - empty=1, full=0, almost_empty=1 (ae_thresh >= 0), almost_full = (af_thresh==0), overflow=0, underflow=0.
  - rst takes priority over all other inputs.
- Write accept: wr_en && !full. A write while full is dropped and sets overflow the next cycle, even if a read is accepted in the same cycle.
- Read accept:
  - Standard mode: rd_en && level!=0.
  - FWFT mode: rd_en && !empty.
  - A rejected rd_en sets underflow. rd_data holds its previous value.
- water_level: +1 on write only, -1 on read only, unchanged when both are accepted. Registered; updates on the edge after the request.
- full, almost_full and almost_empty are combinational from the registered water_level and the live threshold inputs. A threshold change takes effect in the same cycle.
- Standard mode:
  - empty = (level==0).
  - rd_data is valid 1 clock after an accepted read when OUT_REG=0, 2 clocks when OUT_REG=1.
- FWFT mode:
  - A word written into an empty FIFO at edge N appears on rd_data at edge N+2, with empty falling at the same edge. water_level is 1 from edge N.
  - On a pop, the next word is on rd_data at the following edge. empty rises at that edge if no word remains.
  - Back-to-back pops sustain 1 word per clock.
- Pointers wrap modulo 2**ADDR_WIDTH. full and empty are distinguished by water_level, not by pointer compare.
- flush:
  - Same cycle effect as rst on pointers, level, head-valid and flags full/empty.
  - Overrides any wr_en/rd_en in that cycle.
  - Does not clear overflow/underflow. rd_data holds its value.
- err_clr clears both sticky flags. If a new error occurs in the same cycle, the flag stays set (set wins).
- Memory is inferred simple dual-port RAM. Contents are not reset.

Test Plan:
- FWFT=0: reset, write 1..1024 consecutively -> full=1 after the 1024th edge, water_level=1024, almost_full=1 with af_thresh=1011. Then read 1024 -> rd_data sequence 1..1024 at 1-cycle latency, empty=1 at the end, underflow=0.
- Full-FIFO write with a simultaneous read -> write dropped, overflow=1, water_level=1023. err_clr -> overflow=0.
- FWFT=1: single write of 0x00A5 into an empty FIFO -> rd_data=0x00A5 and empty=0 two edges later. rd_en -> empty=1 at the next edge, water_level=0.
- Simultaneous read/write at level 4 for 100 cycles -> water_level stays 4, data order preserved. ae_thresh=4 gives almost_empty=1; changing to 3 gives almost_empty=0 in the same cycle.
- Level 500, assert flush together with wr_en -> level=0, empty=1 next cycle, write discarded. rd_en while empty -> underflow=1.
- OUT_REG=1: read latency is 2 clocks. Assert rst mid-burst -> all outputs return to reset values at the next edge, and a subsequent write/read sequence is correct.
